// File: rtl/array_div16x8.sv
// Restoring array divider: 16-bit dividend / 8-bit divisor with borrow-in, built from
// eight rows of ripple full-subtractor cells and captured in a one-stage output register.

module array_div16x8_fsub (
    input  logic i_a,
    input  logic i_b,
    input  logic i_bin,
    output logic o_diff,
    output logic o_bout
);

    assign o_diff = i_a ^ i_b ^ i_bin;
    assign o_bout = (~i_a & i_b) | (~i_a & i_bin) | (i_b & i_bin);

endmodule

// One divider row: trial-subtract the divisor from {rem, next dividend bit}, restore on borrow.
module array_div16x8_row (
    input  logic [7:0] i_rem,
    input  logic       i_xbit,
    input  logic [7:0] i_y,
    input  logic       i_bin,
    output logic [7:0] o_rem,
    output logic       o_q
);

    logic [8:0] w_t;
    logic [7:0] w_diff;
    logic [9:0] w_borrow;

    assign w_t         = {i_rem, i_xbit};
    assign w_borrow[0] = i_bin;

    genvar g;
    generate
        for (g = 0; g < 8; g++) begin : g_cell
            array_div16x8_fsub u_cell (
                .i_a    (w_t[g]),
                .i_b    (i_y[g]),
                .i_bin  (w_borrow[g]),
                .o_diff (w_diff[g]),
                .o_bout (w_borrow[g+1])
            );
        end
    endgenerate

    // The ninth cell subtracts a constant zero, so only its borrow is needed; its
    // difference bit is always zero whenever the row does not restore.
    assign w_borrow[9] = ~w_t[8] & w_borrow[8];

    assign o_q   = ~w_borrow[9];
    assign o_rem = o_q ? w_diff : w_t[7:0];

endmodule

module array_div16x8 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [15:0] x,
    input  logic [7:0]  y,
    input  logic        bin,
    output logic        out_valid,
    output logic [7:0]  q,
    output logic [7:0]  r,
    output logic        ovf,
    output logic        dz
);

    logic [7:0] w_rem [0:8];
    logic [7:0] w_quo;
    logic [8:0] w_dEff;
    logic       w_dz;
    logic       w_ovf;

    logic       r_valid;
    logic [7:0] r_q;
    logic [7:0] r_r;
    logic       r_ovf;
    logic       r_dz;

    assign w_rem[0] = x[15:8];

    // Row k consumes dividend bit 7-k and produces quotient bit 7-k.
    genvar k;
    generate
        for (k = 0; k < 8; k++) begin : g_row
            array_div16x8_row u_row (
                .i_rem  (w_rem[k]),
                .i_xbit (x[7-k]),
                .i_y    (y),
                .i_bin  (bin),
                .o_rem  (w_rem[k+1]),
                .o_q    (w_quo[7-k])
            );
        end
    endgenerate

    // The array is only meaningful while the high byte is below the effective divisor.
    assign w_dEff = {1'b0, y} + {8'd0, bin};
    assign w_dz   = (y == 8'd0) & ~bin;
    assign w_ovf  = ~w_dz & ({1'b0, x[15:8]} >= w_dEff);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_q     <= 8'd0;
            r_r     <= 8'd0;
            r_ovf   <= 1'b0;
            r_dz    <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_ovf <= w_ovf;
                r_dz  <= w_dz;
                if (w_dz || w_ovf) begin
                    r_q <= 8'hFF;
                    r_r <= 8'hFF;
                end else begin
                    r_q <= w_quo;
                    r_r <= w_rem[8];
                end
            end
        end
    end

    assign out_valid = r_valid;
    assign q         = r_q;
    assign r         = r_r;
    assign ovf       = r_ovf;
    assign dz        = r_dz;

endmodule

// File: tb/tb_array_div16x8.sv
// Scoreboard bench for array_div16x8: stimulus pushes reference results tagged with the
// cycle they are due, a negedge monitor pops and compares, and also checks held outputs.

module tb_array_div16x8;

    typedef struct {
        int         due;
        logic [7:0] q;
        logic [7:0] r;
        logic       ovf;
        logic       dz;
    } expT;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] x;
    logic [7:0]  y;
    logic        bin;
    logic        out_valid;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        ovf;
    logic        dz;

    expT        expQ[$];
    int         checks = 0;
    int         errors = 0;
    int         cycleCount = 0;
    logic [7:0] lastQ = 8'd0;
    logic [7:0] lastR = 8'd0;
    logic       lastOvf = 1'b0;
    logic       lastDz = 1'b0;

    array_div16x8 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .x         (x),
        .y         (y),
        .bin       (bin),
        .out_valid (out_valid),
        .q         (q),
        .r         (r),
        .ovf       (ovf),
        .dz        (dz)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Reference model: plain integer division on the effective divisor.
    function automatic expT refModel(input int xv, input int yv, input int bv);
        expT e;
        int  d;
        d     = yv + bv;
        e.due = 0;
        if (d == 0) begin
            e.q = 8'hFF; e.r = 8'hFF; e.ovf = 1'b0; e.dz = 1'b1;
        end else if (xv / d > 255) begin
            e.q = 8'hFF; e.r = 8'hFF; e.ovf = 1'b1; e.dz = 1'b0;
        end else begin
            e.q = 8'(xv / d); e.r = 8'(xv % d); e.ovf = 1'b0; e.dz = 1'b0;
        end
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drives one cycle of inputs just after a rising edge; valid items go on the scoreboard.
    task automatic applyStimulus(input logic [15:0] xv, input logic [7:0] yv,
                                 input logic bv, input logic vld);
        expT e;
        @(posedge clk);
        #1;
        in_valid = vld;
        x        = xv;
        y        = yv;
        bin      = bv;
        if (vld) begin
            e     = refModel(int'(xv), int'(yv), int'(bv));
            e.due = cycleCount + 1;
            expQ.push_back(e);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_q"},     32'(q),         32'd0);
        checkOutput({tag, "_r"},     32'(r),         32'd0);
        checkOutput({tag, "_ovf"},   32'(ovf),       32'd0);
        checkOutput({tag, "_dz"},    32'(dz),        32'd0);
    endtask

    // Monitor: a result is expected exactly when the queue head is due this cycle.
    always @(negedge clk) begin
        expT e;
        if (rst_n === 1'b1) begin
            if (expQ.size() > 0 && expQ[0].due < cycleCount) begin
                checkOutput("missed_result", 32'(expQ[0].due), 32'(cycleCount));
                void'(expQ.pop_front());
            end
            if (expQ.size() > 0 && expQ[0].due == cycleCount) begin
                e = expQ.pop_front();
                checkOutput("out_valid", 32'(out_valid), 32'd1);
                checkOutput("q",   32'(q),   32'(e.q));
                checkOutput("r",   32'(r),   32'(e.r));
                checkOutput("ovf", 32'(ovf), 32'(e.ovf));
                checkOutput("dz",  32'(dz),  32'(e.dz));
                lastQ = e.q; lastR = e.r; lastOvf = e.ovf; lastDz = e.dz;
            end else begin
                checkOutput("idle_valid", 32'(out_valid), 32'd0);
                checkOutput("hold_q",     32'(q),         32'(lastQ));
                checkOutput("hold_r",     32'(r),         32'(lastR));
                checkOutput("hold_flags", 32'({ovf, dz}), 32'({lastOvf, lastDz}));
            end
        end
    end

    // Directed cases as {x, y, bin}.
    logic [24:0] directed [0:20] = '{
        {16'd8,     8'd4,   1'b0}, {16'd7,     8'd3,   1'b0}, {16'd5,   8'd5, 1'b0},
        {16'd16,    8'd4,   1'b0}, {16'd20,    8'd5,   1'b0}, {16'd15,  8'd3, 1'b0},
        {16'd12,    8'd5,   1'b0}, {16'd40,    8'd13,  1'b0}, {16'd17,  8'd5, 1'b0},
        {16'd199,   8'd7,   1'b0}, {16'd127,   8'd5,   1'b0}, {16'd40,  8'd12, 1'b1},
        {16'd255,   8'd255, 1'b1}, {16'h0500,  8'd5,   1'b0}, {16'h04FF, 8'd5, 1'b0},
        {16'hFFFF,  8'd255, 1'b0}, {16'd100,   8'd0,   1'b0}, {16'd100, 8'd0, 1'b1},
        {16'hFFFF,  8'd255, 1'b1}, {16'hFEFF,  8'd255, 1'b0}, {16'h0000, 8'd0, 1'b1}
    };

    initial begin
        logic [24:0] entry;
        logic [15:0] rx;
        logic [7:0]  ry;
        logic        rb;
        int          d;

        rst_n    = 1'b0;
        in_valid = 1'b1;
        x        = 16'h1234;
        y        = 8'd3;
        bin      = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checkResetState("reset");

        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);

        for (int i = 0; i < 21; i++) begin
            entry = directed[i];
            applyStimulus(entry[24:9], entry[8:1], entry[0], 1'b1);
        end
        applyStimulus(16'd0, 8'd0, 1'b0, 1'b0);
        applyStimulus(16'd0, 8'd0, 1'b0, 1'b0);

        // Four back-to-back items, then reset while a fifth is in flight.
        for (int i = 0; i < 4; i++)
            applyStimulus(16'(1000 + 37 * i), 8'(9 + i), 1'b0, 1'b1);
        applyStimulus(16'd555, 8'd7, 1'b0, 1'b1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkResetState("midreset");
        expQ.delete();
        lastQ = 8'd0; lastR = 8'd0; lastOvf = 1'b0; lastDz = 1'b0;
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;

        applyStimulus(16'd91, 8'd10, 1'b0, 1'b1);
        applyStimulus(16'd0, 8'd0, 1'b0, 1'b0);

        // Randomized traffic with gaps; most items keep the high byte below the divisor.
        for (int i = 0; i < 400; i++) begin
            ry = 8'($urandom_range(0, 255));
            rb = 1'($urandom_range(0, 1));
            d  = int'(ry) + int'(rb);
            if (d > 0 && $urandom_range(0, 3) != 0)
                rx = {8'($urandom_range(0, d - 1)), 8'($urandom_range(0, 255))};
            else
                rx = 16'($urandom_range(0, 65535));
            if ($urandom_range(0, 19) == 0) begin
                ry = 8'd0;
                rb = 1'b0;
            end
            applyStimulus(rx, ry, rb, ($urandom_range(0, 4) != 0));
        end

        applyStimulus(16'd0, 8'd0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
